// File: rtl/riscv_cpu_pkg.sv
// Shared decode-stage types and constants: register address width, JALR operand
// select encoding, interlock FSM states and the in-flight write scoreboard entry.
package riscv_cpu_pkg;

  localparam int ADDR_WIDTH           = 5;
  localparam int JALR_RDATA_MUX_WIDTH = 1;

  localparam logic [JALR_RDATA_MUX_WIDTH-1:0] JALR_RDATA_REG = 1'b0;
  localparam logic [JALR_RDATA_MUX_WIDTH-1:0] JALR_RDATA_MEM = 1'b1;

  typedef enum logic [0:0] {
    HZ_RUN   = 1'b0,
    HZ_FLUSH = 1'b1
  } hazard_state_e;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  is_load;
  } sb_entry_t;

  // x0 is hard-wired zero, so a write to it can never be a dependency.
  function automatic logic reg_match(input logic                  slot_ok,
                                     input logic [ADDR_WIDTH-1:0] slot_dest,
                                     input logic [ADDR_WIDTH-1:0] src);
    return slot_ok & (slot_dest == src) & (src != {ADDR_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot record of in-flight register writes (EX, MEM, WB) and the
// source-operand match logic that turns them into hazard/forward requests.
module hazard_scoreboard
  import riscv_cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] push_dest_i,
  input  logic                  push_load_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic                  use_a_i,
  input  logic                  use_b_i,
  input  logic                  jalr_i,
  output logic                  load_use_o,
  output logic                  jalr_haz_o,
  output logic                  jalr_fwd_mem_o
);

  sb_entry_t ex_r, mem_r, wb_r;
  logic      load_use_s, jalr_haz_s, jalr_fwd_s;

  // Advance the write slots one stage per cycle; a non-pushing cycle inserts an empty slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else begin
      wb_r          <= mem_r;
      mem_r         <= ex_r;
      ex_r.valid    <= push_i;
      ex_r.dest     <= push_i ? push_dest_i : {ADDR_WIDTH{1'b0}};
      ex_r.is_load  <= push_i & push_load_i;
    end
  end

  // Load data is only usable from WB on, and the JALR target is formed in ID, so
  // only a non-load result sitting in MEM can be forwarded to it.
  always_comb begin
    load_use_s = ex_r.valid & ex_r.is_load &
                 ((use_a_i & reg_match(1'b1, ex_r.dest, raddr_a_i)) |
                  (use_b_i & reg_match(1'b1, ex_r.dest, raddr_b_i)));
    jalr_haz_s = jalr_i &
                 (reg_match(ex_r.valid, ex_r.dest, raddr_a_i) |
                  reg_match(mem_r.valid & mem_r.is_load, mem_r.dest, raddr_a_i) |
                  reg_match(wb_r.valid, wb_r.dest, raddr_a_i));
    jalr_fwd_s = jalr_i & ~jalr_haz_s &
                 reg_match(mem_r.valid & ~mem_r.is_load, mem_r.dest, raddr_a_i);
  end

  assign load_use_o     = load_use_s;
  assign jalr_haz_o     = jalr_haz_s;
  assign jalr_fwd_mem_o = jalr_fwd_s;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: stalls IF/ID on load-use and JALR source hazards,
// flushes it after taken branches, and selects the JALR operand source.
module hazard_ctrl
  import riscv_cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            id_valid_i,
  input  logic [ADDR_WIDTH-1:0]           id_raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]           id_raddr_b_i,
  input  logic                            id_use_a_i,
  input  logic                            id_use_b_i,
  input  logic                            id_jalr_i,
  input  logic                            id_reg_we_i,
  input  logic                            id_is_load_i,
  input  logic [ADDR_WIDTH-1:0]           id_dest_i,
  input  logic                            branch_taken_i,
  output logic                            stall_if_o,
  output logic                            stall_id_o,
  output logic                            bubble_o,
  output logic                            flush_o,
  output logic [JALR_RDATA_MUX_WIDTH-1:0] jalr_rdata_mux_o,
  output logic [CNT_WIDTH-1:0]            stall_cnt_o
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  hazard_state_e        state_r, state_s;
  logic [FC_W-1:0]      flush_cnt_r, flush_cnt_s;
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic                 stall_id_r;
  logic                 load_use_s, jalr_haz_s, jalr_fwd_s, haz_s;
  logic                 stall_if_s, bubble_s, flush_s, push_s;

  assign haz_s  = id_valid_i & (load_use_s | jalr_haz_s);
  assign push_s = id_valid_i & id_reg_we_i & (id_dest_i != {ADDR_WIDTH{1'b0}}) &
                  ~bubble_s & ~flush_s;

  hazard_scoreboard u_scoreboard (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .push_i         (push_s),
    .push_dest_i    (id_dest_i),
    .push_load_i    (id_is_load_i),
    .raddr_a_i      (id_raddr_a_i),
    .raddr_b_i      (id_raddr_b_i),
    .use_a_i        (id_use_a_i),
    .use_b_i        (id_use_b_i),
    .jalr_i         (id_jalr_i),
    .load_use_o     (load_use_s),
    .jalr_haz_o     (jalr_haz_s),
    .jalr_fwd_mem_o (jalr_fwd_s)
  );

  // FSM state and remaining-flush counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= HZ_RUN;
      flush_cnt_r <= {FC_W{1'b0}};
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
    end
  end

  // Next state: the branch cycle itself flushes, FLUSH covers the remaining cycles.
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    case (state_r)
      HZ_RUN: begin
        if (branch_taken_i && (FLUSH_CYCLES > 1)) begin
          state_s     = HZ_FLUSH;
          flush_cnt_s = FC_W'(FLUSH_CYCLES - 1);
        end else begin
          state_s     = HZ_RUN;
          flush_cnt_s = {FC_W{1'b0}};
        end
      end
      HZ_FLUSH: begin
        if (branch_taken_i) begin
          state_s     = HZ_FLUSH;
          flush_cnt_s = FC_W'(FLUSH_CYCLES - 1);
        end else if (flush_cnt_r <= FC_W'(1)) begin
          state_s     = HZ_RUN;
          flush_cnt_s = {FC_W{1'b0}};
        end else begin
          state_s     = HZ_FLUSH;
          flush_cnt_s = flush_cnt_r - FC_W'(1);
        end
      end
      default: begin
        state_s     = HZ_RUN;
        flush_cnt_s = {FC_W{1'b0}};
      end
    endcase
  end

  // Outputs: a taken branch outranks a hazard, whose instruction is being killed anyway.
  always_comb begin
    stall_if_s = 1'b0;
    bubble_s   = 1'b0;
    flush_s    = 1'b0;
    case (state_r)
      HZ_RUN: begin
        if (branch_taken_i) begin
          flush_s  = 1'b1;
          bubble_s = 1'b1;
        end else if (haz_s) begin
          stall_if_s = 1'b1;
          bubble_s   = 1'b1;
        end else begin
          stall_if_s = 1'b0;
          bubble_s   = 1'b0;
        end
      end
      HZ_FLUSH: begin
        flush_s  = 1'b1;
        bubble_s = 1'b1;
      end
      default: begin
        stall_if_s = 1'b0;
        bubble_s   = 1'b0;
        flush_s    = 1'b0;
      end
    endcase
  end

  // Saturating stall counter and the reserved back-pressure stall register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
      stall_id_r  <= 1'b0;
    end else begin
      stall_id_r <= 1'b0;
      if (stall_if_s && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign stall_if_o       = stall_if_s;
  assign stall_id_o       = stall_id_r;
  assign bubble_o         = bubble_s;
  assign flush_o          = flush_s;
  assign jalr_rdata_mux_o = jalr_fwd_s ? JALR_RDATA_MEM : JALR_RDATA_REG;
  assign stall_cnt_o      = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl against an issue-history model
// that derives hazards from the age of each in-flight register write.
module tb_hazard_ctrl;
  import riscv_cpu_pkg::*;

  localparam int FC = 2;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic id_valid = 1'b0, id_use_a = 1'b0, id_use_b = 1'b0, id_jalr = 1'b0;
  logic id_reg_we = 1'b0, id_is_load = 1'b0, branch_taken = 1'b0;
  logic [ADDR_WIDTH-1:0] id_raddr_a = '0, id_raddr_b = '0, id_dest = '0;
  logic stall_if, stall_id, bubble, flush;
  logic [JALR_RDATA_MUX_WIDTH-1:0] jalr_mux;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .id_valid_i(id_valid), .id_raddr_a_i(id_raddr_a),
    .id_raddr_b_i(id_raddr_b), .id_use_a_i(id_use_a), .id_use_b_i(id_use_b),
    .id_jalr_i(id_jalr), .id_reg_we_i(id_reg_we), .id_is_load_i(id_is_load),
    .id_dest_i(id_dest), .branch_taken_i(branch_taken), .stall_if_o(stall_if),
    .stall_id_o(stall_id), .bubble_o(bubble), .flush_o(flush),
    .jalr_rdata_mux_o(jalr_mux), .stall_cnt_o(stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each issued write remembers the cycle it left ID; its age tells the stage.
  typedef struct { logic [ADDR_WIDTH-1:0] dest; bit ld; int born; } rec_t;
  rec_t inflight[$];
  int   cyc = 0;
  int   flush_left = 0;
  int   stall_total = 0;
  logic obs_stall, obs_flush, obs_bubble;
  logic [JALR_RDATA_MUX_WIDTH-1:0] obs_mux;
  logic [CW-1:0] obs_cnt;

  function automatic bit slot(input int age, output logic [ADDR_WIDTH-1:0] d, output bit l);
    bit found = 1'b0;
    d = '0;
    l = 1'b0;
    foreach (inflight[i]) begin
      if (cyc - inflight[i].born == age) begin
        found = 1'b1;
        d = inflight[i].dest;
        l = inflight[i].ld;
      end
    end
    return found;
  endfunction

  task automatic model_reset();
    inflight.delete();
    flush_left  = 0;
    stall_total = 0;
  endtask

  // Apply one ID instruction for one cycle, compare every output, then advance the model.
  task automatic step(input logic v, input logic [ADDR_WIDTH-1:0] ra, input logic [ADDR_WIDTH-1:0] rb,
                      input logic ua, input logic ub, input logic jr, input logic we,
                      input logic ld, input logic [ADDR_WIDTH-1:0] rd, input logic br);
    logic [ADDR_WIDTH-1:0] ex_d, mem_d, wb_d;
    bit ex_ok, mem_ok, wb_ok, ex_l, mem_l, wb_l;
    bit lu, jh, fw, haz, e_flush, e_stall, e_bubble;
    int e_cnt;
    id_valid = v; id_raddr_a = ra; id_raddr_b = rb; id_use_a = ua; id_use_b = ub;
    id_jalr = jr; id_reg_we = we; id_is_load = ld; id_dest = rd; branch_taken = br;
    ex_ok  = slot(1, ex_d, ex_l);
    mem_ok = slot(2, mem_d, mem_l);
    wb_ok  = slot(3, wb_d, wb_l);
    lu = ex_ok && ex_l && ((ua && ra != 0 && ra == ex_d) || (ub && rb != 0 && rb == ex_d));
    jh = jr && ra != 0 && ((ex_ok && ra == ex_d) || (mem_ok && mem_l && ra == mem_d) ||
                           (wb_ok && ra == wb_d));
    fw = jr && ra != 0 && mem_ok && !mem_l && ra == mem_d && !jh;
    haz      = v && (lu || jh);
    e_flush  = br || (flush_left > 0);
    e_stall  = haz && !e_flush;
    e_bubble = e_stall || e_flush;
    e_cnt    = (stall_total > (2**CW - 1)) ? (2**CW - 1) : stall_total;
    @(negedge clk);
    check_eq("stall_if", 32'(stall_if), 32'(e_stall));
    check_eq("bubble", 32'(bubble), 32'(e_bubble));
    check_eq("flush", 32'(flush), 32'(e_flush));
    check_eq("stall_id", 32'(stall_id), 32'd0);
    check_eq("jalr_mux", 32'(jalr_mux), fw ? 32'(JALR_RDATA_MEM) : 32'(JALR_RDATA_REG));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(e_cnt));
    obs_stall = stall_if; obs_flush = flush; obs_bubble = bubble;
    obs_mux = jalr_mux; obs_cnt = stall_cnt;
    if (v && we && rd != 0 && !e_bubble) inflight.push_back('{rd, ld, cyc});
    if (e_stall) stall_total++;
    if (br) flush_left = FC - 1;
    else if (flush_left > 0) flush_left--;
    cyc++;
    while (inflight.size() > 0 && cyc - inflight[0].born > 3) void'(inflight.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_stall_if"}, 32'(stall_if), 32'd0);
    check_eq({tag, "_bubble"}, 32'(bubble), 32'd0);
    check_eq({tag, "_flush"}, 32'(flush), 32'd0);
    check_eq({tag, "_stall_id"}, 32'(stall_id), 32'd0);
    check_eq({tag, "_mux"}, 32'(jalr_mux), 32'(JALR_RDATA_REG));
    check_eq({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  // Drop reset part-way through a cycle with the given instruction still in ID.
  task automatic async_reset(input string tag);
    #2;
    branch_taken = 1'b0;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // lw x5 ; add x6,x5,x1
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    step(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0);
    check_eq("lu_stall", 32'(obs_stall), 32'd1);
    check_eq("lu_bubble", 32'(obs_bubble), 32'd1);
    step(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0);
    check_eq("lu_issue", 32'(obs_stall), 32'd0);
    check_eq("lu_cnt", 32'(obs_cnt), 32'd1);
    repeat (3) nop();

    // addi x7 ; jalr x0,0(x7)
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0);
    step(1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    check_eq("jalr_ex_stall", 32'(obs_stall), 32'd1);
    step(1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    check_eq("jalr_fwd_mem", 32'(obs_mux), 32'(JALR_RDATA_MEM));
    check_eq("jalr_fwd_nostall", 32'(obs_stall), 32'd0);
    nop();
    check_eq("jalr_fwd_done", 32'(obs_mux), 32'(JALR_RDATA_REG));
    repeat (3) nop();

    // lw x7 ; jalr 0(x7): waits out EX, MEM-load and WB
    step(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0);
      check_eq("jalr_load_stall", 32'(obs_stall), 32'd1);
    end
    step(1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0);
    check_eq("jalr_load_go", 32'(obs_stall), 32'd0);
    check_eq("jalr_load_mux", 32'(obs_mux), 32'(JALR_RDATA_REG));
    repeat (3) nop();

    // taken branch over a load-use pair: two flush cycles, no stall
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
    step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 1'b1);
    check_eq("br_flush0", 32'(obs_flush), 32'd1);
    check_eq("br_nostall0", 32'(obs_stall), 32'd0);
    step(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11, 1'b0);
    check_eq("br_flush1", 32'(obs_flush), 32'd1);
    step(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11, 1'b0);
    check_eq("br_done", 32'(obs_flush), 32'd0);
    check_eq("br_ex_cleared", 32'(obs_stall), 32'd0);
    repeat (3) nop();

    // writes to x0 never create a dependency
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    check_eq("x0_nostall", 32'(obs_stall), 32'd0);

    // reset during a stall and during FLUSH
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
    id_valid = 1'b1; id_raddr_a = 5'd4; id_use_a = 1'b1; id_jalr = 1'b0;
    async_reset("rst_stall");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    async_reset("rst_flush");

    // randomized traffic over a small register set to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset("rst_rand");
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
           1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 11) == 0));
    end

    // saturation: lw x5,0(x5) repeated stalls every other cycle
    async_reset("rst_sat");
    for (int i = 0; i < 2 * (2**CW) + 100; i++)
      step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    check_eq("cnt_saturated", 32'(obs_cnt), 32'(2**CW - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
